adventure_move_ctrl: RTL and testbench
======================================

// Module: adventure_move_ctrl
// PURPOSE
//  Front-end controller for the adventure room FSM. Synchronises and debounces the
//  raw N/S/E/W/restart buttons, and arbitrates simultaneous presses to at most one move.
//  Issues single-cycle move pulses to the room FSM and tracks sword inventory (drives v).
//  Detects win/death and sequences game restart by driving the room FSM's reset.
// PARAMETERS
//  DEB_CYCLES     4  consecutive synchronised samples needed to accept a level change
//  RESTART_CYCLES 8  cycles room_reset_n is held low on power-up/restart (>=2)
//  MOVE_W         8  width of move counter
// PORTS
//  clk           in   1       system clock, all logic on posedge
//  reset         in   1       asynchronous, active-low reset
//  btn_n/s/e/w   in   1 each  raw asynchronous direction buttons, active-high
//  btn_restart   in   1       raw asynchronous restart button, active-high
//  room_sw       in   1       room FSM "in sword room" flag
//  room_win      in   1       room FSM win flag
//  room_dead     in   1       room FSM death flag
//  mv_n/s/e/w    out  1 each  one-cycle move pulses to room FSM n/s/e/w
//  has_sword     out  1       sword held; wired to room FSM v
//  room_reset_n  out  1       active-low reset to room FSM
//  move_count    out  MOVE_W  accepted moves since last restart, saturating
//  won, lost     out  1 each  latched game result
//  busy          out  1       high in any state other than PLAY
// BEHAVIOUR
//  Reset (async, reset=0): state=INIT, timer=RESTART_CYCLES, mv_*=0, has_sword=0,
//    room_reset_n=0, move_count=0, won=lost=0, busy=1, debouncers cleared to released.
//  Input path: 2-flop synchroniser per button, then debounce: the level is accepted only
//    after DEB_CYCLES equal consecutive samples. A press event is a 0->1 accepted-level
//    edge, one cycle wide. A held button never repeats.
//  Press-to-pulse latency: 2 sync + DEB_CYCLES + 1 (event) + 1 (registered mv_*).
//  States:
//    INIT/RESTART: room_reset_n=0, timer decrements per cycle; at timer==1 go PLAY
//      with room_reset_n=1. Entering RESTART clears has_sword, move_count, won, lost.
//    PLAY: restart event -> RESTART (timer=RESTART_CYCLES). Else room_win -> OVER, won=1.
//      Else room_dead -> OVER, lost=1. Else direction event -> pulse mv_x next cycle
//      (priority N>S>E>W; losers dropped, not queued), move_count+1, go SETTLE.
//      room_sw==1 in PLAY sets has_sword (sticky until restart).
//    SETTLE: 2 cycles; room FSM outputs lag a move by 2 cycles. All direction events are
//      dropped. A restart event still goes RESTART. Then back to PLAY.
//    OVER: direction events ignored, won/lost hold. Restart event -> RESTART.
//  Simultaneous events: restart beats win/dead beats direction. room_win and room_dead
//    both high -> won=1 only.
//  move_count saturates at 2^MOVE_W-1; it counts issued mv pulses only.
//  At most one mv_* high in any cycle; mv_* is never high outside the cycle after PLAY.
//  Reset mid-operation: immediate return to reset values regardless of state or timers.
// STRUCTURE
//  Package adventure_pkg: state encoding localparams (INIT, PLAY, SETTLE, OVER, RESTART),
//    direction index constants (DIR_N=0, DIR_S=1, DIR_E=2, DIR_W=3).
//  Sub-module btn_debounce (synchroniser + debounce counter + edge detect, params
//    DEB_CYCLES). Five instances. Arbitration, FSM and counters stay in this module.
// TESTING
//  1 Reset release: room_reset_n=0 for 8 cycles then 1; all other outputs at reset values.
//  2 btn_e held 20 cycles -> exactly one mv_e pulse at cycle 2+4+2 after assert;
//    move_count=1, no repeat.
//  3 btn_n and btn_w rise same cycle -> only mv_n; a btn_s event inside SETTLE -> no pulse.
//  4 Glitch: btn_s high for 3 cycles (DEB_CYCLES=4) -> no event, no mv_s.
//  5 room_sw=1 for 1 cycle in PLAY -> has_sword=1, held after room_sw=0; room_win=1 ->
//    won=1, busy=1, direction presses ignored. Restart -> 8 cycles room_reset_n=0,
//    has_sword=0, move_count=0, won=0.
//  6 Assert move_count=255 with MOVE_W=8, press once more -> stays 255.
//    Assert reset during SETTLE -> all outputs at reset values.

Source files
------------

// File: rtl/adventure_pkg.sv
// Shared types and constants for the adventure room front-end controller:
// controller state encoding, direction indices and the move arbiter.
package adventure_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        PLAY    = 3'd1,
        SETTLE  = 3'd2,
        OVER    = 3'd3,
        RESTART = 3'd4
    } state_t;

    localparam int DIR_N    = 0;
    localparam int DIR_S    = 1;
    localparam int DIR_E    = 2;
    localparam int DIR_W    = 3;
    localparam int NUM_DIRS = 4;

    // Room FSM outputs lag a move by this many cycles
    localparam int SETTLE_CYCLES = 2;

    // Fixed-priority pick N > S > E > W; losing requests are dropped
    function automatic logic [NUM_DIRS-1:0] pick_dir(input logic [NUM_DIRS-1:0] ev);
        logic [NUM_DIRS-1:0] grant;
        grant = '0;
        if (ev[DIR_N])      grant[DIR_N] = 1'b1;
        else if (ev[DIR_S]) grant[DIR_S] = 1'b1;
        else if (ev[DIR_E]) grant[DIR_E] = 1'b1;
        else if (ev[DIR_W]) grant[DIR_W] = 1'b1;
        return grant;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, level debounce requiring DEB_CYCLES
// equal consecutive samples, and a one-cycle press pulse on each accepted 0->1.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;

    // Synchronise, count samples that disagree with the accepted level, flag rising edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/adventure_move_ctrl.sv
// Front-end controller for the adventure room FSM: debounces the buttons,
// issues at most one move pulse per accepted press, tracks the sword, latches
// the game result and sequences the room FSM reset on power-up and restart.
module adventure_move_ctrl
    import adventure_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int RESTART_CYCLES = 8,
    parameter int MOVE_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_n,
    input  logic              btn_s,
    input  logic              btn_e,
    input  logic              btn_w,
    input  logic              btn_restart,
    input  logic              room_sw,
    input  logic              room_win,
    input  logic              room_dead,
    output logic              mv_n,
    output logic              mv_s,
    output logic              mv_e,
    output logic              mv_w,
    output logic              has_sword,
    output logic              room_reset_n,
    output logic [MOVE_W-1:0] move_count,
    output logic              won,
    output logic              lost,
    output logic              busy
);

    localparam int TIMER_W = $clog2(RESTART_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE     = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_RESTART = TIMER_W'(RESTART_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_SETTLE  = TIMER_W'(SETTLE_CYCLES);
    localparam logic [MOVE_W-1:0]  COUNT_MAX     = '1;

    logic [NUM_DIRS-1:0] dir_raw;
    logic [NUM_DIRS-1:0] dir_ev;
    logic [NUM_DIRS-1:0] grant;
    logic                restart_ev;
    logic [NUM_DIRS-1:0] mv;
    logic [TIMER_W-1:0]  timer;
    state_t              state;

    assign dir_raw[DIR_N] = btn_n;
    assign dir_raw[DIR_S] = btn_s;
    assign dir_raw[DIR_E] = btn_e;
    assign dir_raw[DIR_W] = btn_w;

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (dir_raw[i]),
            .press (dir_ev[i])
        );
    end

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_restart (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_restart),
        .press (restart_ev)
    );

    assign grant = pick_dir(dir_ev);

    assign mv_n = mv[DIR_N];
    assign mv_s = mv[DIR_S];
    assign mv_e = mv[DIR_E];
    assign mv_w = mv[DIR_W];

    // Game sequencing: restart beats win/dead, which beat a direction move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= INIT;
            timer        <= TIMER_RESTART;
            mv           <= '0;
            has_sword    <= 1'b0;
            room_reset_n <= 1'b0;
            move_count   <= '0;
            won          <= 1'b0;
            lost         <= 1'b0;
            busy         <= 1'b1;
        end else begin
            mv <= '0;
            case (state)
                INIT, RESTART: begin
                    if (timer == TIMER_ONE) begin
                        state        <= PLAY;
                        room_reset_n <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                PLAY: begin
                    if (room_sw) has_sword <= 1'b1;
                    if (restart_ev) begin
                        state        <= RESTART;
                        timer        <= TIMER_RESTART;
                        room_reset_n <= 1'b0;
                        has_sword    <= 1'b0;
                        move_count   <= '0;
                        won          <= 1'b0;
                        lost         <= 1'b0;
                        busy         <= 1'b1;
                    end else if (room_win) begin
                        state <= OVER;
                        won   <= 1'b1;
                        busy  <= 1'b1;
                    end else if (room_dead) begin
                        state <= OVER;
                        lost  <= 1'b1;
                        busy  <= 1'b1;
                    end else if (|dir_ev) begin
                        mv    <= grant;
                        if (move_count != COUNT_MAX) move_count <= move_count + 1'b1;
                        state <= SETTLE;
                        timer <= TIMER_SETTLE;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (restart_ev) begin
                        state        <= RESTART;
                        timer        <= TIMER_RESTART;
                        room_reset_n <= 1'b0;
                        has_sword    <= 1'b0;
                        move_count   <= '0;
                        won          <= 1'b0;
                        lost         <= 1'b0;
                    end else if (timer == TIMER_ONE) begin
                        state <= PLAY;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                OVER: begin
                    if (restart_ev) begin
                        state        <= RESTART;
                        timer        <= TIMER_RESTART;
                        room_reset_n <= 1'b0;
                        has_sword    <= 1'b0;
                        move_count   <= '0;
                        won          <= 1'b0;
                        lost         <= 1'b0;
                    end
                end
                default: begin
                    state        <= INIT;
                    timer        <= TIMER_RESTART;
                    room_reset_n <= 1'b0;
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adventure_move_ctrl.sv
// Bench for adventure_move_ctrl: scoreboard of expected move pulses (direction,
// cycle, move count) checked by a monitor, plus per-scenario inline checks.
module tb_adventure_move_ctrl;
    import adventure_pkg::*;

    localparam int LAT       = 8;    // 2 sync + 4 debounce + 1 event + 1 registered pulse
    localparam int COUNT_MAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0, btn_restart = 1'b0;
    logic       room_sw = 1'b0, room_win = 1'b0, room_dead = 1'b0;
    logic       mv_n, mv_s, mv_e, mv_w, has_sword, room_reset_n, won, lost, busy;
    logic [7:0] move_count;

    adventure_move_ctrl #(.DEB_CYCLES(4), .RESTART_CYCLES(8), .MOVE_W(8)) dut (
        .clk(clk), .reset(reset),
        .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w), .btn_restart(btn_restart),
        .room_sw(room_sw), .room_win(room_win), .room_dead(room_dead),
        .mv_n(mv_n), .mv_s(mv_s), .mv_e(mv_e), .mv_w(mv_w),
        .has_sword(has_sword), .room_reset_n(room_reset_n), .move_count(move_count),
        .won(won), .lost(lost), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int dir;
        int cycle;
        int count;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    // Monitor: every move pulse must match the head of the scoreboard
    always @(negedge clk) begin : mon
        logic [3:0] bits;
        logic [3:0] want;
        exp_t       e;
        bits = {mv_w, mv_e, mv_s, mv_n};
        if (reset && bits != 4'b0000) begin
            n_checks++;
            if ($countones(bits) != 1) begin
                n_fail++;
                $display("FAIL mv_onehot: got %b required exactly one bit", bits);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_mv: got %b at cycle %0d required no pulse", bits, cyc);
            end else begin
                e    = sb_q.pop_front();
                want = 4'b0001 << e.dir;
                if (bits !== want) begin
                    n_fail++;
                    $display("FAIL mv_dir: got %b required %b", bits, want);
                end
                n_checks++;
                if (cyc != e.cycle) begin
                    n_fail++;
                    $display("FAIL mv_cycle: got %0d required %0d", cyc, e.cycle);
                end
                n_checks++;
                if (int'(move_count) != e.count) begin
                    n_fail++;
                    $display("FAIL mv_count: got %0d required %0d", move_count, e.count);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic set_btn(input int dir, input logic v);
        case (dir)
            DIR_N:   btn_n = v;
            DIR_S:   btn_s = v;
            DIR_E:   btn_e = v;
            default: btn_w = v;
        endcase
    endtask

    // Called at a negedge; holds the button for 'hold' cycles then releases it
    task automatic press_dir(input int dir, input bit expect_pulse, input int hold);
        exp_t e;
        if (expect_pulse) begin
            if (exp_count < COUNT_MAX) exp_count++;
            e.dir   = dir;
            e.cycle = cyc + LAT;
            e.count = exp_count;
            sb_q.push_back(e);
        end
        set_btn(dir, 1'b1);
        repeat (hold) @(negedge clk);
        set_btn(dir, 1'b0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({mv_n, mv_s, mv_e, mv_w, has_sword, room_reset_n, won, lost, busy} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL %s_flags: got %b required 000000001", name,
                     {mv_n, mv_s, mv_e, mv_w, has_sword, room_reset_n, won, lost, busy});
        end
        n_checks++;
        if (move_count !== 8'd0) begin
            n_fail++;
            $display("FAIL %s_count: got %0d required 0", name, move_count);
        end
    endtask

    task automatic check_reset_release(input string name);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (room_reset_n !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_low%0d: got %b required 0", name, i, room_reset_n);
            end
            @(negedge clk);
        end
        n_checks++;
        if (room_reset_n !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_play: got room_reset_n=%b busy=%b required 1 0", name, room_reset_n, busy);
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1 check_reset_values("reset_hold");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        check_reset_release("reset_release");
    endtask

    task automatic test_single_move();
        @(negedge clk);
        press_dir(DIR_E, 1'b1, 20);
        repeat (10) @(negedge clk);
        wait_drain("single", 20);
        n_checks++;
        if (int'(move_count) != exp_count || exp_count != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d required 1", move_count);
        end
    endtask

    task automatic test_arbitration();
        exp_t e;
        @(negedge clk);
        if (exp_count < COUNT_MAX) exp_count++;
        e.dir = DIR_N; e.cycle = cyc + LAT; e.count = exp_count;
        sb_q.push_back(e);
        btn_n = 1'b1;
        btn_w = 1'b1;
        @(negedge clk);
        btn_s = 1'b1;               // its event lands while the controller is settling
        repeat (12) @(negedge clk);
        btn_n = 1'b0; btn_w = 1'b0; btn_s = 1'b0;
        repeat (12) @(negedge clk);
        wait_drain("arb", 20);
        n_checks++;
        if (int'(move_count) != exp_count) begin
            n_fail++;
            $display("FAIL arb_count: got %0d required %0d", move_count, exp_count);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        btn_s = 1'b1;
        repeat (3) @(negedge clk);
        btn_s = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (int'(move_count) != exp_count) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d required %0d", move_count, exp_count);
        end
    endtask

    task automatic test_sword_win_restart();
        @(negedge clk);
        room_sw = 1'b1;
        @(negedge clk);
        room_sw = 1'b0;
        n_checks++;
        if (has_sword !== 1'b1) begin
            n_fail++;
            $display("FAIL sword_set: got %b required 1", has_sword);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (has_sword !== 1'b1) begin
            n_fail++;
            $display("FAIL sword_hold: got %b required 1", has_sword);
        end
        room_win = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({won, lost, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL win_flags: got %b required 101", {won, lost, busy});
        end
        press_dir(DIR_E, 1'b0, 10);
        repeat (10) @(negedge clk);
        n_checks++;
        if (int'(move_count) != exp_count || won !== 1'b1) begin
            n_fail++;
            $display("FAIL over_ignore: got count=%0d won=%b required %0d 1", move_count, won, exp_count);
        end
        room_win = 1'b0;
        btn_restart = 1'b1;
        repeat (LAT) @(negedge clk);
        btn_restart = 1'b0;
        exp_count = 0;
        n_checks++;
        if ({has_sword, won, lost, busy} !== 4'b0001 || move_count !== 8'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got sword/won/lost/busy=%b count=%0d required 0001 0",
                     {has_sword, won, lost, busy}, move_count);
        end
        check_reset_release("restart");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < COUNT_MAX; i++) begin
            @(negedge clk);
            press_dir(DIR_W, 1'b1, 8);
            repeat (8) @(negedge clk);
        end
        wait_drain("sat_fill", 20);
        n_checks++;
        if (move_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_full: got %0d required 255", move_count);
        end
        @(negedge clk);
        press_dir(DIR_S, 1'b1, 8);
        repeat (8) @(negedge clk);
        wait_drain("sat_extra", 20);
        n_checks++;
        if (move_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d required 255", move_count);
        end
    endtask

    task automatic test_reset_in_settle();
        @(negedge clk);
        press_dir(DIR_N, 1'b1, LAT);   // returns in the cycle the pulse is visible
        @(posedge clk);
        #2 reset = 1'b0;              // controller is in its second settle cycle
        #1 check_reset_values("settle_reset");
        wait_drain("settle", 2);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 0;
        check_reset_release("settle_release");
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_arbitration();
        test_glitch();
        test_sword_win_restart();
        test_saturation();
        test_reset_in_settle();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
